// File: rtl/rx_frame_pkg.sv
// Shared state encoding, error codes and defaults for the rx_frame_ctrl byte framer.
package rx_frame_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef logic [2:0] state_t;

  localparam state_t ST_HUNT    = 3'd0;
  localparam state_t ST_LEN     = 3'd1;
  localparam state_t ST_PAYLOAD = 3'd2;
  localparam state_t ST_CSUM    = 3'd3;
  localparam state_t ST_DRAIN   = 3'd4;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_LEN     = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_e;

  // A length field is usable when it is non-zero and fits the payload buffer.
  function automatic logic len_acceptable(input logic [7:0] len, input int max_len);
    return (len != 8'd0) && (int'({24'd0, len}) <= max_len);
  endfunction

endpackage

// File: rtl/rx_frame_buf.sv
// Payload store for one frame: synchronous write, combinational read, storage not reset.
module rx_frame_buf #(
  parameter int MAX_LEN = 16,
  parameter int AW      = 5
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  localparam int IW = $clog2(MAX_LEN);

  logic [7:0] mem [MAX_LEN];

  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < MAX_LEN)) begin
      mem[wr_addr[IW-1:0]] <= wr_data;
    end
  end

  // Out-of-range reads return zero rather than aliasing onto a lower entry.
  assign rd_data = (int'(rd_addr) < MAX_LEN) ? mem[rd_addr[IW-1:0]] : 8'd0;

endmodule

// File: rtl/rx_frame_ctrl.sv
// UART frame receiver: SYNC, LEN, payload, XOR checksum, then drains the payload to a consumer.
// Define RX_FRAME_TIMEOUT_EN to add the inter-byte timeout (error code 3).
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       overrun,
  output logic       busy
);

  localparam int PW = $clog2(MAX_LEN + 1);

  state_t      state;
  logic [PW-1:0] len_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [7:0]  csum_q;
  err_code_e   err_q;
  logic [7:0]  rd_data;
  logic        in_frame;
  logic        last_wr;
  logic        buf_wr;
  logic        timed_out;

  assign in_frame = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CSUM);
  assign last_wr  = (wr_ptr == len_q - 1'b1);
  assign buf_wr   = (state == ST_PAYLOAD) && rx_valid;

  rx_frame_buf #(
    .MAX_LEN (MAX_LEN),
    .AW      (PW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (buf_wr),
    .wr_addr (wr_ptr),
    .wr_data (rx_data),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

`ifdef RX_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  // Fire on the edge where the idle count would reach TIMEOUT_CLKS-1; a byte on that edge wins.
  localparam logic [TW-1:0] TO_TERM = TW'(TIMEOUT_CLKS - 2);

  logic [TW-1:0] to_cnt;

  assign timed_out = in_frame && !rx_valid && (to_cnt == TO_TERM);

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (!in_frame || rx_valid || timed_out) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_HUNT;
      len_q     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      csum_q    <= '0;
      err_q     <= ERR_NONE;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        ST_HUNT: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            state <= ST_LEN;
          end
        end
        ST_LEN: begin
          if (rx_valid) begin
            if (len_acceptable(rx_data, MAX_LEN)) begin
              len_q  <= rx_data[PW-1:0];
              csum_q <= rx_data;
              wr_ptr <= '0;
              state  <= ST_PAYLOAD;
            end else begin
              frame_err <= 1'b1;
              err_q     <= ERR_LEN;
              state     <= ST_HUNT;
            end
          end
        end
        ST_PAYLOAD: begin
          if (rx_valid) begin
            csum_q <= csum_q ^ rx_data;
            wr_ptr <= wr_ptr + 1'b1;
            if (last_wr) begin
              state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (rx_valid) begin
            if (rx_data == csum_q) begin
              frame_ok <= 1'b1;
              rd_ptr   <= '0;
              state    <= ST_DRAIN;
            end else begin
              frame_err <= 1'b1;
              err_q     <= ERR_CSUM;
              state     <= ST_HUNT;
            end
          end
        end
        ST_DRAIN: begin
          // The consumer owns the buffer until the last byte leaves; new bytes are dropped.
          overrun <= rx_valid;
          if (out_ready) begin
            if (out_last) begin
              rd_ptr <= '0;
              state  <= ST_HUNT;
            end else begin
              rd_ptr <= rd_ptr + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_HUNT;
        end
      endcase
      if (timed_out) begin
        frame_err <= 1'b1;
        err_q     <= ERR_TIMEOUT;
        state     <= ST_HUNT;
      end
    end
  end

  assign out_valid = (state == ST_DRAIN);
  assign out_data  = out_valid ? rd_data : 8'd0;
  assign out_last  = out_valid && (rd_ptr == len_q - 1'b1);
  assign err_code  = err_q;
  assign busy      = (state != ST_HUNT);

endmodule

// File: doc/rx_frame_ctrl.md
RX_FRAME_CTRL -- requirements
Module: rx_frame_ctrl

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-002 Parameter MAX_LEN, default 16: maximum payload bytes per frame.
REQ-003 Parameter TIMEOUT_CLKS, default 20000: inter-byte timeout in clk cycles (2 byte times at 50 MHz / 50 kbaud).
REQ-004 clk  input  1  system clock, rising edge; single clock domain.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rx_data  input  8  received byte from the UART receiver.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle.
REQ-008 out_data  output  8  payload byte to the consumer.
REQ-009 out_valid  output  1  out_data is valid.
REQ-010 out_ready  input  1  consumer accepts out_data.
REQ-011 out_last  output  1  out_data is the final payload byte of the frame.
REQ-012 frame_ok  output  1  one-cycle pulse when a frame passes its checksum.
REQ-013 frame_err  output  1  one-cycle pulse when a frame is discarded.
REQ-014 err_code  output  2  error cause, valid with frame_err: 1 = bad length, 2 = bad checksum, 3 = timeout.
REQ-015 overrun  output  1  one-cycle pulse when a byte is dropped during DRAIN.
REQ-016 busy  output  1  high in every state except HUNT.

Function
REQ-017 The frame format SHALL be: SYNC_BYTE, LEN, LEN payload bytes, CSUM, where CSUM = XOR of LEN and all payload bytes.
REQ-018 The FSM SHALL use states HUNT, LEN, PAYLOAD, CSUM and DRAIN.
REQ-019 HUNT: rx_valid with rx_data == SYNC_BYTE -> LEN; all other bytes are ignored.
REQ-020 LEN: LEN 0 or LEN > MAX_LEN -> frame_err with code 1, then HUNT; otherwise store LEN, seed the XOR, then PAYLOAD.
REQ-021 PAYLOAD: each byte is written to the buffer at wr_ptr and XORed in; the LEN-th byte -> CSUM.
REQ-022 CSUM: on a match, frame_ok pulses in the first DRAIN cycle; on a mismatch, frame_err with code 2 pulses and the FSM returns to HUNT.
REQ-023 DRAIN: out_valid is high and out_data = buf[rd_ptr]; rd_ptr advances on out_valid && out_ready.
REQ-024 out_last is high when rd_ptr == LEN-1; the last accepted byte returns the FSM to HUNT on the next cycle.
REQ-025 out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-026 rx_valid during DRAIN: the byte is dropped and overrun pulses; SYNC_BYTE is not hunted.
REQ-027 LEN, PAYLOAD and CSUM: the timeout counter clears on rx_valid and increments otherwise.
REQ-028 When the timeout counter reaches TIMEOUT_CLKS-1, frame_err with code 3 pulses and the FSM returns to HUNT.
REQ-029 If rx_valid coincides with the terminal count, the byte wins and no timeout fires.
REQ-030 Pulse outputs are registered; frame_err and frame_ok are never high in the same cycle.
REQ-031 err_code holds its last value between frame_err pulses.

Reset
REQ-032 rst SHALL set the state to HUNT, clear both pointers, the XOR and the timeout counter, and drive every output to 0 on the next clock edge.
REQ-033 rst mid-frame or mid-DRAIN SHALL abandon the frame without asserting frame_err; buffer contents are don't-care.

Configuration
REQ-034 With RX_FRAME_TIMEOUT_EN defined, the timeout counter and error code 3 SHALL be implemented.
REQ-035 Without RX_FRAME_TIMEOUT_EN, no counter exists, err_code never equals 3, and the FSM waits indefinitely for bytes.

Structure
REQ-036 Package rx_frame_pkg SHALL hold the state enum, the err_code enum (ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TIMEOUT) and the default SYNC_BYTE constant.
REQ-037 Sub-module rx_frame_buf SHALL hold the payload buffer: MAX_LEN x 8 registers, synchronous write, combinational read, no reset on the storage.

Verification
REQ-038 Send A5 03 11 22 33 03, out_ready=1 -> frame_ok once; out_data 11, 22, 33 on consecutive cycles; out_last on 33; busy low after.
REQ-039 Send A5 03 11 22 33 04 -> frame_err with err_code=2; out_valid never asserts; state is HUNT.
REQ-040 Send A5 00, then A5 11 -> two frame_err pulses with err_code=1; leading bytes 7E 7E before A5 are ignored.
REQ-041 Send A5 02 11, then idle 20000 cycles -> frame_err with err_code=3 exactly 19999 cycles after the 11 byte; repeat without the macro -> no error.
REQ-042 Valid frame with out_ready low for 5 cycles -> out_data stable; a byte 55 during DRAIN -> overrun pulse, payload unchanged.
REQ-043 Assert rst during PAYLOAD of A5 04 ... -> all outputs 0, no frame_err; next valid frame is received correctly.
